// File: rtl/traffic_pkg.sv
// Shared light encodings, timer state enum and light decode helper for the
// traffic phase timer.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;

  // One-hot lamp encodings driven by the light controller.
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;

  // Phase timer control states.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } timer_state_e;

  // True only for exactly one of the three legal lamp encodings.
  function automatic logic light_legal(input logic [LIGHT_W-1:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into timing ticks: counts 0..TICK_DIV-1 while enabled
// and flags the wrap cycle. clear restarts the count from 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // Tick fires in the cycle whose edge wraps the counter.
  assign tick = enable && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Phase timer for a traffic light controller. Watches the lamp state, times
// each phase in prescaled ticks and pulses advance when the phase expires.
// Optional pedestrian extension of the red phase is compiled in with the
// macro PHASE_TIMER_PED_EN.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 4,
  parameter int unsigned RED_TICKS    = 8,
  parameter int unsigned GREEN_TICKS  = 6,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned PED_TICKS    = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LIGHT_W-1:0] light,
  input  logic               ped_req,
  output logic               advance,
  output logic [CNT_W-1:0]   remaining,
  output logic               ped_walk,
  output logic               fault
);

  timer_state_e       state_q;
  timer_state_e       state_d;
  logic [LIGHT_W-1:0] light_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [CNT_W-1:0]   remaining_d;
  logic               advance_q;
  logic               advance_d;
  logic               ped_walk_q;
  logic               ped_walk_d;
  logic               fault_q;
  logic               fault_d;
  logic               ped_pending_q;
  logic               ped_pending_d;

  logic               legal_c;
  logic               load_c;
  logic               tick_c;

  // A load is a change to a new legal lamp state.
  assign legal_c = light_legal(light);
  assign load_c  = legal_c && (light != light_q);

  // Prescaler runs only while a phase is being timed; each load restarts it.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_c),
    .enable (state_q == ST_COUNT),
    .tick   (tick_c)
  );

`ifndef PHASE_TIMER_PED_EN
  // Pedestrian input and extension are not used in this build.
  logic unused_ped_c;
  assign unused_ped_c = ped_req | (|CNT_W'(PED_TICKS));
`endif

  // Next-state and registered-output logic for the timer FSM.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    advance_d     = 1'b0;
    ped_walk_d    = ped_walk_q;
    fault_d       = fault_q;
    ped_pending_d = ped_pending_q;

`ifdef PHASE_TIMER_PED_EN
    if (ped_req) begin
      ped_pending_d = 1'b1;
    end
`else
    ped_pending_d = 1'b0;
`endif

    case (state_q)
      ST_FAULT: begin
        // Terminal until reset.
        remaining_d = '0;
        ped_walk_d  = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        if (!legal_c) begin
          state_d     = ST_FAULT;
          remaining_d = '0;
          ped_walk_d  = 1'b0;
          fault_d     = 1'b1;
        end else if (load_c) begin
          // New phase: load its duration; an abandoned phase never advances.
          state_d    = ST_COUNT;
          ped_walk_d = 1'b0;
          case (light)
            LIGHT_RED:    remaining_d = CNT_W'(RED_TICKS);
            LIGHT_YELLOW: remaining_d = CNT_W'(YELLOW_TICKS);
            default:      remaining_d = CNT_W'(GREEN_TICKS);
          endcase
`ifdef PHASE_TIMER_PED_EN
          // A red load consumes any pending request, including one this cycle.
          if (light == LIGHT_RED) begin
            if (ped_pending_q || ped_req) begin
              remaining_d = CNT_W'(RED_TICKS + PED_TICKS);
              ped_walk_d  = 1'b1;
            end
            ped_pending_d = 1'b0;
          end
`endif
        end else if ((state_q == ST_COUNT) && tick_c) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            advance_d = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      light_q       <= '0;
      remaining_q   <= '0;
      advance_q     <= 1'b0;
      ped_walk_q    <= 1'b0;
      fault_q       <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      light_q       <= light;
      remaining_q   <= remaining_d;
      advance_q     <= advance_d;
      ped_walk_q    <= ped_walk_d;
      fault_q       <= fault_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign advance   = advance_q;
  assign remaining = remaining_q;
  assign ped_walk  = ped_walk_q;
  assign fault     = fault_q;

endmodule
